// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: first-word-fall-through FIFO of {pc, inst}
// pairs with early fetch back-pressure, flush, and a sticky overflow flag.
module inst_queue #(
  parameter int unsigned ADDR   = 32,
  parameter int unsigned INST   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MARGIN = 1
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            flush,
  input  logic            in_e_,
  input  logic [ADDR-1:0] in_pc,
  input  logic [INST-1:0] in_inst,
  output logic            fetch_stall,
  input  logic            dec_stall,
  output logic            out_e_,
  output logic [ADDR-1:0] out_pc,
  output logic [INST-1:0] out_inst,
  output logic            overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ADDR + INST;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Handshake decode; flush masks the head so nothing is consumed that cycle
  always_comb begin
    full        = (count == CW'(DEPTH));
    out_e_      = (count == '0) | flush;
    pop         = ~out_e_ & ~dec_stall;
    push        = ~in_e_ & ~flush & (~full | pop);
    drop        = ~in_e_ & ~flush & full & ~pop;
    fetch_stall = (CW'(DEPTH) - count) <= CW'(MARGIN);
    {out_pc, out_inst} = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {in_pc, in_inst};
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      // Sticky until reset: a dropped word is a fetch protocol violation
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Randomized self-checking bench for inst_queue against a queue-based model.
module tb_inst_queue;
  localparam int ADDR   = 32;
  localparam int INST   = 32;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 1;

  logic            clk = 1'b0;
  logic            reset_;
  logic            flush;
  logic            in_e_;
  logic [ADDR-1:0] in_pc;
  logic [INST-1:0] in_inst;
  logic            fetch_stall;
  logic            dec_stall;
  logic            out_e_;
  logic [ADDR-1:0] out_pc;
  logic [INST-1:0] out_inst;
  logic            overflow;

  inst_queue #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
    .clk(clk), .reset_(reset_), .flush(flush), .in_e_(in_e_), .in_pc(in_pc),
    .in_inst(in_inst), .fetch_stall(fetch_stall), .dec_stall(dec_stall),
    .out_e_(out_e_), .out_pc(out_pc), .out_inst(out_inst), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of pending words plus a sticky drop flag
  logic [ADDR-1:0] q_pc[$];
  logic [INST-1:0] q_inst[$];
  logic [ADDR-1:0] popped[$];
  logic            m_ovf;

  logic            exp_e, exp_stall, exp_ovf;
  logic [ADDR-1:0] exp_pc;
  logic [INST-1:0] exp_inst;
  logic            obs_e, obs_stall, obs_ovf;
  logic [ADDR-1:0] obs_pc;
  logic [INST-1:0] obs_inst;

  task automatic model_reset();
    q_pc.delete();
    q_inst.delete();
    popped.delete();
    m_ovf = 1'b0;
  endtask

  // Snapshot DUT and model mid-cycle, then advance both across one clock edge
  task automatic tick();
    bit do_pop, do_push;
    @(negedge clk);
    exp_e     = (q_pc.size() == 0) || flush;
    exp_stall = (DEPTH - q_pc.size()) <= MARGIN;
    exp_ovf   = m_ovf;
    exp_pc    = (q_pc.size() > 0) ? q_pc[0] : '0;
    exp_inst  = (q_inst.size() > 0) ? q_inst[0] : '0;
    obs_e = out_e_; obs_stall = fetch_stall; obs_ovf = overflow;
    obs_pc = out_pc; obs_inst = out_inst;
    do_pop  = !exp_e && !dec_stall;
    do_push = !in_e_ && !flush && (q_pc.size() < DEPTH || do_pop);
    @(posedge clk);
    if (flush) begin
      q_pc.delete();
      q_inst.delete();
    end else begin
      if (do_pop) begin
        popped.push_back(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (do_push) begin
        q_pc.push_back(in_pc);
        q_inst.push_back(in_inst);
      end
      if (!in_e_ && !do_push) m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_e_ = 1'b1; dec_stall = 1'b0; in_pc = '0; in_inst = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    reset_ = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [ADDR-1:0] pc);
    in_e_ = 1'b0; in_pc = pc; in_inst = $urandom;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (obs_e !== 1'b1) begin bad++; $display("FAIL reset out_e_ got=%b exp=1", obs_e); end
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL reset fetch_stall got=%b exp=0", obs_stall); end
      total++; if (obs_pc !== '0 || obs_inst !== '0) begin bad++; $display("FAIL reset out_pc/inst got=%h/%h exp=0", obs_pc, obs_inst); end
      total++; if (obs_ovf !== 1'b0) begin bad++; $display("FAIL reset overflow got=%b exp=0", obs_ovf); end
    end
  endtask

  task automatic test_stream();
    logic [ADDR-1:0] pcs [3];
    logic            ee  [5];
    pcs = '{32'h100, 32'h104, 32'h108};
    ee  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) push_word(pcs[i]); else in_e_ = 1'b1;
      tick();
      total++; if (obs_e !== ee[i]) begin bad++; $display("FAIL stream out_e_ cyc=%0d got=%b exp=%b", i, obs_e, ee[i]); end
      if (i >= 1 && i <= 3) begin
        total++; if (obs_pc !== pcs[i-1] || obs_inst !== exp_inst) begin bad++; $display("FAIL stream head cyc=%0d got=%h/%h exp=%h/%h", i, obs_pc, obs_inst, pcs[i-1], exp_inst); end
      end
    end
  endtask

  task automatic test_fill_overflow();
    logic [ADDR-1:0] pcs [4];
    pcs = '{32'h10, 32'h14, 32'h18, 32'h1c};
    apply_reset();
    dec_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push_word(pcs[i]); else if (i == 4) push_word(32'hdead); else in_e_ = 1'b1;
      tick();
      total++; if (obs_stall !== (i >= 3)) begin bad++; $display("FAIL fill fetch_stall cyc=%0d got=%b exp=%b", i, obs_stall, i >= 3); end
      total++; if (obs_ovf !== (i == 5)) begin bad++; $display("FAIL fill overflow cyc=%0d got=%b exp=%b", i, obs_ovf, i == 5); end
    end
    dec_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (obs_e !== (i == 4)) begin bad++; $display("FAIL drain out_e_ cyc=%0d got=%b exp=%b", i, obs_e, i == 4); end
      if (i < 4) begin
        total++; if (obs_pc !== pcs[i]) begin bad++; $display("FAIL drain out_pc cyc=%0d got=%h exp=%h", i, obs_pc, pcs[i]); end
      end
      total++; if (obs_ovf !== 1'b1) begin bad++; $display("FAIL drain overflow sticky got=%b exp=1", obs_ovf); end
    end
  endtask

  task automatic test_async_reset();
    push_word(32'h55);
    tick();
    in_e_ = 1'b1;
    @(negedge clk);
    #2 reset_ = 1'b0;
    #1;
    total++; if (out_e_ !== 1'b1 || overflow !== 1'b0 || fetch_stall !== 1'b0) begin
      bad++; $display("FAIL async_reset out_e_/overflow/stall got=%b/%b/%b exp=1/0/0", out_e_, overflow, fetch_stall);
    end
    @(negedge clk);
    reset_ = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_pop();
    logic [ADDR-1:0] order [5];
    order = '{32'h20, 32'h24, 32'h28, 32'h2c, 32'h200};
    apply_reset();
    dec_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin push_word(order[i]); tick(); end
    dec_stall = 1'b0;
    push_word(32'h200);
    tick();
    total++; if (obs_pc !== 32'h20 || obs_e !== 1'b0) begin bad++; $display("FAIL fullpop head got=%h e=%b exp=20 e=0", obs_pc, obs_e); end
    in_e_ = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick();
      if (i == 1) begin
        total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL fullpop count_held fetch_stall got=%b exp=1", obs_stall); end
      end
      if (i < 5) begin
        total++; if (obs_pc !== order[i] || obs_e !== 1'b0) begin bad++; $display("FAIL fullpop order cyc=%0d got=%h exp=%h", i, obs_pc, order[i]); end
      end else begin
        total++; if (obs_e !== 1'b1) begin bad++; $display("FAIL fullpop empty got=%b exp=1", obs_e); end
      end
      total++; if (obs_ovf !== 1'b0) begin bad++; $display("FAIL fullpop overflow got=%b exp=0", obs_ovf); end
    end
  endtask

  task automatic test_wrap();
    logic [ADDR-1:0] sent[$];
    int n = 0;
    int cyc = 0;
    apply_reset();
    while (popped.size() < 12 && cyc < 300) begin
      dec_stall = ($urandom_range(0, 99) < 40);
      if (n < 12 && (DEPTH - q_pc.size()) > MARGIN && $urandom_range(0, 3) != 0) begin
        push_word(32'h1000 + 32'(n * 4));
        sent.push_back(in_pc);
        n++;
      end else in_e_ = 1'b1;
      tick();
      cyc++;
      total++; if (obs_e !== exp_e || obs_stall !== exp_stall) begin bad++; $display("FAIL wrap e/stall got=%b/%b exp=%b/%b", obs_e, obs_stall, exp_e, exp_stall); end
      if (!exp_e) begin
        total++; if (obs_pc !== exp_pc || obs_inst !== exp_inst) begin bad++; $display("FAIL wrap head got=%h/%h exp=%h/%h", obs_pc, obs_inst, exp_pc, exp_inst); end
      end
    end
    total++; if (popped.size() != 12 || popped != sent) begin bad++; $display("FAIL wrap order got=%0d words exp=12 in order", popped.size()); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_flush();
    apply_reset();
    dec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin push_word(32'h30 + 32'(i * 4)); tick(); end
    dec_stall = 1'b0;
    flush = 1'b1;
    push_word(32'h300);
    tick();
    total++; if (obs_e !== 1'b1) begin bad++; $display("FAIL flush mask out_e_ got=%b exp=1", obs_e); end
    total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL flush stall_before got=%b exp=1", obs_stall); end
    flush = 1'b0;
    push_word(32'h400);
    tick();
    total++; if (obs_e !== 1'b1 || obs_stall !== 1'b0) begin bad++; $display("FAIL flush after e/stall got=%b/%b exp=1/0", obs_e, obs_stall); end
    in_e_ = 1'b1;
    tick();
    total++; if (obs_e !== 1'b0 || obs_pc !== 32'h400) begin bad++; $display("FAIL flush new_head got=%b/%h exp=0/400", obs_e, obs_pc); end
    tick();
    total++; if (obs_e !== 1'b1) begin bad++; $display("FAIL flush drained got=%b exp=1", obs_e); end
    total++; if (popped.size() != 1 || popped[0] !== 32'h400) begin bad++; $display("FAIL flush popped got=%0d words exp=1 (0x400 only)", popped.size()); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      flush     = ($urandom_range(0, 99) < 8);
      dec_stall = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 99) < 70) push_word($urandom); else in_e_ = 1'b1;
      tick();
      total++; if (obs_e !== exp_e || obs_stall !== exp_stall || obs_ovf !== exp_ovf) begin
        bad++; $display("FAIL random cyc=%0d e/stall/ovf got=%b/%b/%b exp=%b/%b/%b", i, obs_e, obs_stall, obs_ovf, exp_e, exp_stall, exp_ovf);
      end
      if (!exp_e) begin
        total++; if (obs_pc !== exp_pc || obs_inst !== exp_inst) begin bad++; $display("FAIL random head cyc=%0d got=%h/%h exp=%h/%h", i, obs_pc, obs_inst, exp_pc, exp_inst); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset_ = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    test_reset();
    test_stream();
    test_fill_overflow();
    test_async_reset();
    test_full_pop();
    test_wrap();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
